// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//    Two-stage pipelined logic unit: bitwise, shift and rotate operations on
//    two WIDTH-bit operands, with valid/ready handshakes on both sides.
//
//    Optional feature macro: LOGU_ROTATE_EN
//       defined   : opcodes 110/111 rotate left/right, err is always 0
//       undefined : opcodes 110/111 give result 0 and err 1, no rotate logic
//
//    Ports
//       clk        rising-edge clock
//       rst_n      asynchronous, active-low reset
//       in_valid   operand/opcode presented
//       in_ready   block accepts when in_valid && in_ready
//       a, b       operands; b[SHW-1:0] is the shift/rotate amount
//       opsel      operation select
//       out_valid  result presented
//       out_ready  consumer accepts when out_valid && out_ready
//       result     operation result
//       zero       result == 0
//       parity     XOR-reduction of result
//       err        opcode not supported in this build
//       ops_done   count of results consumed (wraps)
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH),
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opsel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity,
   output logic             err,
   output logic [CNTW-1:0]  ops_done
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_op;
   logic             s2_valid;

   logic             s1_load;
   logic             s2_load;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] c_result;
   logic             c_err;

`ifdef LOGU_ROTATE_EN
   logic [2*WIDTH-1:0] rotl_w;
   logic [2*WIDTH-1:0] rotr_w;
`endif

   // Each stage loads when it is empty or its contents move on this cycle.
   assign s2_load   = !s2_valid || out_ready;
   assign s1_load   = !s1_valid || s2_load;
   assign in_ready  = s1_load;
   assign out_valid = s2_valid;
   assign sh        = s1_b[SHW-1:0];

   always_comb begin
      c_result = '0;
      c_err    = 1'b0;
`ifdef LOGU_ROTATE_EN
      // Shifting the doubled operand wraps the bits around; amount 0 yields a.
      rotl_w = {s1_a, s1_a} << sh;
      rotr_w = {s1_a, s1_a} >> sh;
`endif
      case (s1_op)
         3'b000: c_result = s1_a & s1_b;
         3'b001: c_result = s1_a | s1_b;
         3'b010: c_result = s1_a ^ s1_b;
         3'b011: c_result = ~s1_a;
         3'b100: c_result = s1_a << sh;
         3'b101: c_result = s1_a >> sh;
`ifdef LOGU_ROTATE_EN
         3'b110: c_result = rotl_w[2*WIDTH-1:WIDTH];
         3'b111: c_result = rotr_w[WIDTH-1:0];
`else
         3'b110,
         3'b111: c_err = 1'b1;
`endif
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
         s2_valid <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         parity   <= 1'b0;
         err      <= 1'b0;
         ops_done <= '0;
      end else begin
         if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_a  <= a;
               s1_b  <= b;
               s1_op <= opsel;
            end
         end
         // Output registers only change when real data arrives, so a bubble
         // leaves the last result in place.
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               result <= c_result;
               zero   <= (c_result == '0);
               parity <= ^c_result;
               err    <= c_err;
            end
         end
         if (s2_valid && out_ready)
            ops_done <= ops_done + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe
//    Scoreboard bench for logic_unit_pipe (WIDTH=8, CNTW=16). The driver pushes
//    the expected response when a transfer is accepted; the monitor pops and
//    compares on every consumed output. Rotate expectations follow whether
//    LOGU_ROTATE_EN is defined for the build.
module tb_logic_unit_pipe;

   typedef struct packed {
      logic [7:0] r;
      logic       z;
      logic       p;
      logic       e;
   } exp_t;

`ifdef LOGU_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [2:0]  opsel;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  result;
   logic        zero;
   logic        parity;
   logic        err;
   logic [15:0] ops_done;

   int          n_vec  = 0;
   int          n_fail = 0;
   exp_t        sb[$];
   logic [15:0] exp_done = '0;
   logic        held_v = 1'b0;
   exp_t        held;

   logic_unit_pipe #(.WIDTH(8), .CNTW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opsel(opsel),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .parity(parity), .err(err),
      .ops_done(ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] r, input logic e);
      exp_t x;
      x.r = r;
      x.z = (r == 8'h00);
      x.p = ^r;
      x.e = e;
      return x;
   endfunction

   // Bit-by-bit reference; rotate opcodes follow the build option.
   function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] op);
      logic [7:0] r;
      int         s;
      r = '0;
      s = int'(mb[2:0]);
      if (op >= 3'd6 && !ROT) return mk(8'h00, 1'b1);
      for (int i = 0; i < 8; i++) begin
         case (op)
            3'd0: r[i] = ma[i] & mb[i];
            3'd1: r[i] = ma[i] | mb[i];
            3'd2: r[i] = ma[i] ^ mb[i];
            3'd3: r[i] = !ma[i];
            3'd4: r[i] = (i >= s) ? ma[i-s] : 1'b0;
            3'd5: r[i] = (i + s < 8) ? ma[i+s] : 1'b0;
            3'd6: r[i] = ma[(i - s + 8) % 8];
            default: r[i] = ma[(i + s) % 8];
         endcase
      end
      return mk(r, 1'b0);
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top,
                       input exp_t ex, output int waited);
      a        = ta;
      b        = tb_;
      opsel    = top;
      in_valid = 1'b1;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      n_vec++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0 want 1 within 50 cycles");
      end else begin
         sb.push_back(ex);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("drain_queue_empty", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: ops_done tracking, hold stability and result comparison.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         exp_done = '0;
         held_v   = 1'b0;
      end else begin
         chk("ops_done_track", 32'(ops_done), 32'(exp_done));
         if (held_v)
            chk("hold_stable", 32'({result, zero, parity, err}), 32'(held));
         if (out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: got result=%0h with empty scoreboard", result);
            end else begin
               exp_t ex;
               ex = sb.pop_front();
               if ({result, zero, parity, err} !== ex) begin
                  n_fail++;
                  $display("FAIL result: got r=%0h z=%0b p=%0b e=%0b want r=%0h z=%0b p=%0b e=%0b",
                           result, zero, parity, err, ex.r, ex.z, ex.p, ex.e);
               end
            end
            exp_done = exp_done + 16'd1;
         end
         held_v = out_valid && !out_ready;
         held   = {result, zero, parity, err};
      end
   end

   initial begin
      int   w;
      int   stalls;
      logic [15:0] base;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [2:0]  ro;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      opsel     = '0;
      out_ready = 1'b1;

      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result",    32'(result),    32'd0);
      chk("rst_zero",      32'(zero),      32'd0);
      chk("rst_parity",    32'(parity),    32'd0);
      chk("rst_err",       32'(err),       32'd0);
      chk("rst_ops_done",  32'(ops_done),  32'd0);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("in_ready_after_reset", 32'(in_ready), 32'd1);

      // Single op with latency check.
      send(8'hF0, 8'h0F, 3'b000, mk(8'h00, 1'b0), w);
      @(negedge clk);
      chk("latency_not_yet", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1 chk("ops_done_first", 32'(ops_done), 32'd1);

      // Directed vectors, back to back.
      send(8'h81, 8'h0B, 3'b100, mk(8'h08, 1'b0), w);
      send(8'h81, 8'h0B, 3'b101, mk(8'h10, 1'b0), w);
      send(8'h81, 8'h0B, 3'b011, mk(8'h7E, 1'b0), w);
      send(8'h81, 8'h01, 3'b110, ROT ? mk(8'h03, 1'b0) : mk(8'h00, 1'b1), w);
      send(8'h81, 8'h01, 3'b111, ROT ? mk(8'hC0, 1'b0) : mk(8'h00, 1'b1), w);
      send(8'hA0, 8'h05, 3'b001, mk(8'hA5, 1'b0), w);
      send(8'hFF, 8'h0F, 3'b010, mk(8'hF0, 1'b0), w);
      send(8'h5A, 8'h08, 3'b100, mk(8'h5A, 1'b0), w);
      send(8'h01, 8'h09, 3'b111, ROT ? mk(8'h80, 1'b0) : mk(8'h00, 1'b1), w);
      send(8'h3C, 8'h01, 3'b010, mk(8'h3D, 1'b0), w);
      send(8'hFF, 8'h80, 3'b000, mk(8'h80, 1'b0), w);
      drain();

      // Backpressure: two buffered, third waits until the first is consumed.
      out_ready = 1'b0;
      send(8'h12, 8'h01, 3'b001, mk(8'h13, 1'b0), w);
      send(8'h0F, 8'h3C, 3'b000, mk(8'h0C, 1'b0), w);
      a        = 8'h80;
      b        = 8'h07;
      opsel    = 3'b101;
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("bp_in_ready_held", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("bp_accept_with_consume", 32'(in_ready), 32'd1);
      sb.push_back(mk(8'h01, 1'b0));
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();

      // Streaming: one per cycle with out_ready held high.
      base   = ops_done;
      stalls = 0;
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         ro = 3'($urandom_range(0, 7));
         send(ra, rb, ro, model(ra, rb, ro), w);
         stalls += w;
      end
      chk("stream_stalls", 32'(stalls), 32'd0);
      drain();
      chk("stream_ops_done", 32'(ops_done - base), 32'd20);

      // Asynchronous reset with both stages full.
      out_ready = 1'b0;
      send(8'h11, 8'h22, 3'b001, mk(8'h33, 1'b0), w);
      send(8'h44, 8'h0F, 3'b000, mk(8'h04, 1'b0), w);
      chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
      chk("pre_reset_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ops_done",  32'(ops_done),  32'd0);
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      #4 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_stale_output", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      send(8'hC3, 8'h02, 3'b101, mk(8'h30, 1'b0), w);
      drain();
      chk("post_reset_ops_done", 32'(ops_done), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish before 200000");
      $fatal(1);
   end

endmodule
